// File: rtl/matrix_scan_pkg.sv
// Shared constants and scan FSM encoding for the LED matrix scanner.
package matrix_scan_pkg;

  localparam int FRAME_BYTES   = 128;
  localparam int DEFAULT_DWELL = 256;
  localparam int BYTE_W        = 8;
  localparam int ROW_W         = 4;
  localparam int ROW_BITS      = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    LATCH   = 2'd2,
    DISPLAY = 2'd3
  } scan_state_t;

endpackage

// File: rtl/matrix_scan_if.sv
// Frame input from the RAM reader plus column/row drive toward the LED panel.
interface matrix_scan_if;
  import matrix_scan_pkg::*;

  logic [BYTE_W-1:0] din;
  logic              din_synced;
  logic              din_done;
  logic              col_sdata;
  logic              col_sclk;
  logic              col_latch;
  logic [ROW_W-1:0]  row_sel;
  logic              row_oe_n;
  logic              frame_ready;

  modport master (
    output din, din_synced, din_done,
    input  col_sdata, col_sclk, col_latch, row_sel, row_oe_n, frame_ready
  );

  modport slave (
    input  din, din_synced, din_done,
    output col_sdata, col_sclk, col_latch, row_sel, row_oe_n, frame_ready
  );
endinterface

// File: rtl/matrix_shifter.sv
// Serialises one 64-bit row word MSB first as sclk-low/sclk-high bit pairs, then a latch pulse.
module matrix_shifter
  import matrix_scan_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ROW_BITS-1:0] row_word,
  output logic                col_sdata,
  output logic                col_sclk,
  output logic                col_latch,
  output logic                done
);

  localparam int PH_W = $clog2(2 * ROW_BITS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * ROW_BITS - 1);

  logic            busy;
  logic [PH_W-1:0] ph;
  logic [ROW_BITS-2:0] shreg;
  logic            advance_bit;

  // Next data bit is presented on the cycle after an sclk-high cycle.
  assign advance_bit = busy && ph[0] && (ph != PH_LAST);
  assign done        = busy && (ph == PH_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      ph        <= '0;
      col_sdata <= 1'b0;
      col_sclk  <= 1'b0;
      col_latch <= 1'b0;
    end else begin
      col_latch <= 1'b0;
      if (start) begin
        busy      <= 1'b1;
        ph        <= '0;
        col_sclk  <= 1'b0;
        col_sdata <= row_word[ROW_BITS-1];
      end else if (busy) begin
        if (done) begin
          busy      <= 1'b0;
          col_sclk  <= 1'b0;
          col_latch <= 1'b1;
        end else begin
          ph       <= ph + 1'b1;
          col_sclk <= ~ph[0];
          if (advance_bit) col_sdata <= shreg[ROW_BITS-2];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start)            shreg <= row_word[ROW_BITS-2:0];
    else if (advance_bit) shreg <= {shreg[ROW_BITS-3:0], 1'b0};
  end

endmodule

// File: rtl/matrix_scan.sv
// Captures a 128-byte frame from the RAM reader and scans it row by row onto the LED matrix.
module matrix_scan
  import matrix_scan_pkg::*;
#(
  parameter int DWELL         = DEFAULT_DWELL,
  parameter int ROWS          = 16,
  parameter int BYTES_PER_ROW = 8
) (
  input  logic         clk,
  input  logic         rst,
  matrix_scan_if.slave bus
);

  localparam int ADDR_W = $clog2(FRAME_BYTES);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  logic [BYTE_W-1:0] frame_mem [FRAME_BYTES];
  logic              synced_p0;
  logic [ADDR_W:0]   byte_cnt;
  logic              wr_en;

  // Top bit of byte_cnt doubles as the "frame full" flag and blocks further writes.
  assign wr_en = bus.din_synced & ~synced_p0 & ~byte_cnt[ADDR_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      synced_p0       <= 1'b0;
      byte_cnt        <= '0;
      bus.frame_ready <= 1'b0;
    end else begin
      synced_p0 <= bus.din_synced;
      if (wr_en) byte_cnt <= byte_cnt + 1'b1;
      if (byte_cnt[ADDR_W] && bus.din_done) bus.frame_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) frame_mem[byte_cnt[ADDR_W-1:0]] <= bus.din;
  end

  scan_state_t         state;
  logic [ROW_W-1:0]    row;
  logic [ROW_W-1:0]    next_row;
  logic [15:0]         dwell_cnt;
  logic                shift_start;
  logic                shift_done;
  logic [ROW_BITS-1:0] row_word;

  always_comb begin
    next_row = '0;
    if (state == DISPLAY && row != ROW_W'(ROWS - 1)) next_row = row + 1'b1;
    shift_start = (state == IDLE && bus.frame_ready) ||
                  (state == DISPLAY && dwell_cnt == DWELL_LAST);
  end

  // Row word is gathered for the row about to be shifted, first byte in the MSBs.
  always_comb begin
    row_word = '0;
    for (int b = 0; b < BYTES_PER_ROW; b++) begin
      row_word[ROW_BITS-1-BYTE_W*b -: BYTE_W] =
        frame_mem[ADDR_W'(int'(next_row) * BYTES_PER_ROW + b)];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      row          <= '0;
      dwell_cnt    <= '0;
      bus.row_sel  <= '0;
      bus.row_oe_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (shift_start) begin
            state <= SHIFT;
            row   <= next_row;
          end
        end
        SHIFT: begin
          if (shift_done) begin
            state       <= LATCH;
            bus.row_sel <= row;
          end
        end
        LATCH: begin
          state        <= DISPLAY;
          bus.row_oe_n <= 1'b0;
          dwell_cnt    <= '0;
        end
        DISPLAY: begin
          if (shift_start) begin
            state        <= SHIFT;
            row          <= next_row;
            bus.row_oe_n <= 1'b1;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic sdata, sclk, latch;

  matrix_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .start     (shift_start),
    .row_word  (row_word),
    .col_sdata (sdata),
    .col_sclk  (sclk),
    .col_latch (latch),
    .done      (shift_done)
  );

  assign bus.col_sdata = sdata;
  assign bus.col_sclk  = sclk;
  assign bus.col_latch = latch;

endmodule

// File: doc/matrix_scan.md
MATRIX_SCAN -- requirements
Module: matrix_scan

Interface
REQ-001 Parameter DWELL, default 256, cycles each row is displayed (output enabled); legal range 1..65535.
REQ-002 Parameter ROWS, default 16, number of LED rows; fixed with BYTES_PER_ROW so ROWS*BYTES_PER_ROW = 128.
REQ-003 Parameter BYTES_PER_ROW, default 8, bytes (8 columns each) per row; 64 columns total.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 din  input  8  frame byte from the RAM reader stage.
REQ-007 din_synced  input  1  RAM reader strobe; a 0->1 transition marks din valid.
REQ-008 din_done  input  1  RAM reader end-of-frame flag, level.
REQ-009 col_sdata  output  1  serial column data to external shift registers.
REQ-010 col_sclk  output  1  column shift clock; external registers sample on its rising edge.
REQ-011 col_latch  output  1  one-cycle pulse transferring shifted columns to outputs.
REQ-012 row_sel  output  4  active row index.
REQ-013 row_oe_n  output  1  row driver enable, active-low.
REQ-014 frame_ready  output  1  high once a full 128-byte frame is captured.

Function
REQ-015 Capture SHALL detect din_synced rising edge using a registered copy; the edge cycle writes din to buf[wr_addr] and increments wr_addr.
REQ-016 Captured byte count SHALL saturate at 128; edges after the 128th byte SHALL be ignored until reset.
REQ-017 frame_ready SHALL assert the cycle after both count = 128 and din_done = 1 are true, and stay high until reset.
REQ-018 din_synced held high for multiple cycles SHALL produce exactly one write.
REQ-019 Scan FSM states: IDLE, SHIFT, LATCH, DISPLAY.
REQ-020 IDLE -> SHIFT on frame_ready = 1, row counter = 0.
REQ-021 SHIFT SHALL emit 64 bits in 128 cycles: per bit, cycle A col_sclk = 0 with col_sdata valid, cycle B col_sclk = 1 with col_sdata unchanged.
REQ-022 Bit order SHALL be buf[row*8 + 0] MSB first through buf[row*8 + 7] LSB last.
REQ-023 SHIFT -> LATCH after bit 63 cycle B; LATCH lasts 1 cycle with col_latch = 1, col_sclk = 0, row_sel updated to the row just shifted.
REQ-024 LATCH -> DISPLAY; DISPLAY lasts exactly DWELL cycles with row_oe_n = 0.
REQ-025 DISPLAY -> SHIFT with row incremented; row 15 wraps to 0; scanning SHALL run continuously.
REQ-026 row_oe_n SHALL be 1 in IDLE, SHIFT and LATCH.
REQ-027 Row period SHALL be exactly 129 + DWELL cycles.
REQ-028 Capture SHALL continue independently of scan; scan only starts after frame_ready, so buffer is never read while partially written.

Reset
REQ-029 While rst = 0: col_sdata = 0, col_sclk = 0, col_latch = 0, row_sel = 0, row_oe_n = 1, frame_ready = 0, FSM = IDLE, byte count = 0, synced history = 0.
REQ-030 Reset mid-scan or mid-capture SHALL abort immediately; buffer contents need not be cleared and SHALL NOT be read before a new complete frame.
REQ-031 First valid capture edge after reset release SHALL write address 0.

Structure
REQ-032 Shared package SHALL hold FRAME_BYTES = 128, state encoding for the scan FSM and the default DWELL.
REQ-033 One sub-module, matrix_shifter, SHALL implement SHIFT/LATCH bit sequencing given a 64-bit row word and start pulse, returning a done pulse.

Verification
REQ-034 Feed 128 bytes value = address, synced toggling 0/1 each cycle, done at end -> frame_ready high 1 cycle after byte 128 with done; buf[5] = 8'h05.
REQ-035 Row 0 bytes 8'hA5,00,00,00,00,00,00,8'h01 -> first 8 sampled bits 1,0,1,0,0,1,0,1; bit 63 = 1; col_latch pulse at cycle 128 after SHIFT entry.
REQ-036 DWELL = 4 -> row_oe_n low exactly 4 cycles per row; row period 133 cycles; row_sel sequence 0..15 then 0.
REQ-037 din_synced held high 5 cycles with din = 8'h3C -> single write; byte count increments by 1.
REQ-038 Send 130 edges -> bytes 129, 130 ignored; buf[0] unchanged.
REQ-039 Assert rst during row 7 DISPLAY -> next cycle row_oe_n = 1, row_sel = 0, frame_ready = 0; no scan until new full frame.
